// File: rtl/udp_axi_pkg.sv
// Shared definitions for the UDP-to-AXI bridge: frame types, header layout,
// FSM state encoding and small header-building helpers.
package udp_axi_pkg;

   localparam logic [7:0] FRAME_TYPE_RD = 8'h01;
   localparam logic [7:0] FRAME_TYPE_WR = 8'h02;

   // Two header words precede the read data in every frame.
   localparam int HDR_WORDS = 2;

   // Header word 0 field positions.
   localparam int HDR0_TYPE_LSB = 24;
   localparam int HDR0_OVF_BIT  = 23;
   localparam int HDR0_ID_LSB   = 16;
   localparam int HDR0_LEN_LSB  = 0;

   // Header word 1 field positions.
   localparam int HDR1_RESP_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_START,
      ST_SEND,
      ST_WAIT_DONE
   } state_t;

   // Source currently presented on udp_tx_data.
   typedef enum logic [1:0] {
      SEL_ZERO,
      SEL_HDR,
      SEL_BUF
   } data_sel_t;

   function automatic logic [31:0] make_hdr0(input logic [7:0] ftype,
                                             input logic       ovf,
                                             input logic [3:0] id,
                                             input logic [7:0] len);
      logic [31:0] h;
      h = '0;
      h[HDR0_TYPE_LSB +: 8] = ftype;
      h[HDR0_OVF_BIT]       = ovf;
      h[HDR0_ID_LSB +: 4]   = id;
      h[HDR0_LEN_LSB +: 8]  = len;
      return h;
   endfunction

   function automatic logic [31:0] make_hdr1(input logic [1:0] resp);
      logic [31:0] h;
      h = '0;
      h[HDR1_RESP_LSB +: 2] = resp;
      return h;
   endfunction

endpackage

// File: rtl/udp_axi_resp_tx_if.sv
// Bundle of the AXI R/B return channels and the UDP transmit handshake.
// The slave view is the response framer; the master view is its surroundings
// (AXI master port plus UDP tx engine).
interface udp_axi_resp_tx_if;

   // AXI read-data channel
   logic [3:0]  MASTER_RD_BACK_ID;
   logic [31:0] MASTER_RD_DATA;
   logic [1:0]  MASTER_RD_DATA_RESP;
   logic        MASTER_RD_DATA_LAST;
   logic        MASTER_RD_DATA_VALID;
   logic        MASTER_RD_DATA_READY;

   // AXI write-response channel
   logic [3:0]  MASTER_WR_BACK_ID;
   logic [1:0]  MASTER_WR_BACK_RESP;
   logic        MASTER_WR_BACK_VALID;
   logic        MASTER_WR_BACK_READY;

   // UDP tx engine
   logic        udp_tx_start;
   logic [15:0] udp_tx_byte_num;
   logic        udp_tx_req;
   logic [31:0] udp_tx_data;
   logic        udp_tx_done;

   modport slave (
      input  MASTER_RD_BACK_ID, MASTER_RD_DATA, MASTER_RD_DATA_RESP,
             MASTER_RD_DATA_LAST, MASTER_RD_DATA_VALID,
      output MASTER_RD_DATA_READY,
      input  MASTER_WR_BACK_ID, MASTER_WR_BACK_RESP, MASTER_WR_BACK_VALID,
      output MASTER_WR_BACK_READY,
      output udp_tx_start, udp_tx_byte_num, udp_tx_data,
      input  udp_tx_req, udp_tx_done
   );

   modport master (
      output MASTER_RD_BACK_ID, MASTER_RD_DATA, MASTER_RD_DATA_RESP,
             MASTER_RD_DATA_LAST, MASTER_RD_DATA_VALID,
      input  MASTER_RD_DATA_READY,
      output MASTER_WR_BACK_ID, MASTER_WR_BACK_RESP, MASTER_WR_BACK_VALID,
      input  MASTER_WR_BACK_READY,
      input  udp_tx_start, udp_tx_byte_num, udp_tx_data,
      output udp_tx_req, udp_tx_done
   );

endinterface

// File: rtl/udp_resp_buf.sv
// Read-data payload buffer: simple dual-port RAM, synchronous write,
// registered read that holds its value when no read is requested.
module udp_resp_buf #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          gmii_rx_clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH];

   // Store incoming beats and register the addressed word on a read.
   // NOTE: the array and its read register carry no reset so they map onto
   // block RAM; the framer never presents a word that was not written first.
   // NOTE: non-blocking assignments here so every register samples pre-edge values.
   always_ff @(posedge gmii_rx_clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/udp_axi_resp_tx.sv
// Return path of the UDP-to-AXI bridge: collects one AXI read burst or one
// write response, then streams it to the UDP tx engine as header + data words.
module udp_axi_resp_tx
   import udp_axi_pkg::*;
#(
   parameter int MAX_BEATS = 256,
   parameter int BUF_AW    = 8
) (
   input logic              gmii_rx_clk,
   input logic              rstn,
   udp_axi_resp_tx_if.slave bus
);

   state_t            state, state_nxt;
   logic [BUF_AW:0]   beat_cnt;
   logic [BUF_AW+1:0] w_idx;
   logic [BUF_AW+1:0] last_idx;
   logic [3:0]        id_q;
   logic [1:0]        resp_acc;
   logic              ovf;
   logic              is_wr;
   data_sel_t         data_sel;
   logic [31:0]       hdr_q;
   logic [31:0]       hdr0, hdr1;
   logic [31:0]       buf_rdata;

   logic r_hs, b_hs, buf_full, buf_we, buf_re, word_issue, last_word, frame_end;

   assign r_hs       = (state == ST_COLLECT) && bus.MASTER_RD_DATA_VALID;
   assign b_hs       = (state == ST_IDLE) && bus.MASTER_WR_BACK_VALID;
   assign buf_full   = (beat_cnt >= (BUF_AW+1)'(MAX_BEATS));
   assign buf_we     = r_hs && !buf_full;
   assign word_issue = (state == ST_SEND) && bus.udp_tx_req;
   assign buf_re     = word_issue && (w_idx >= (BUF_AW+2)'(HDR_WORDS));
   assign last_idx   = {1'b0, beat_cnt} + (BUF_AW+2)'(HDR_WORDS - 1);
   assign last_word  = (w_idx == last_idx);
   assign frame_end  = bus.udp_tx_done && ((state == ST_SEND) || (state == ST_WAIT_DONE));

   assign hdr0 = make_hdr0(is_wr ? FRAME_TYPE_WR : FRAME_TYPE_RD, ovf, id_q,
                           is_wr ? 8'h00 : 8'(beat_cnt) - 8'd1);
   assign hdr1 = make_hdr1(resp_acc);

   udp_resp_buf #(
      .DEPTH(MAX_BEATS),
      .AW   (BUF_AW)
   ) u_buf (
      .gmii_rx_clk(gmii_rx_clk),
      .wr_en      (buf_we),
      .wr_addr    (beat_cnt[BUF_AW-1:0]),
      .wr_data    (bus.MASTER_RD_DATA),
      .rd_en      (buf_re),
      .rd_addr    (w_idx[BUF_AW-1:0] - BUF_AW'(HDR_WORDS)),
      .rd_data    (buf_rdata)
   );

   // Byte count is meaningful only while a frame is being announced or sent.
   assign bus.udp_tx_byte_num = ((state == ST_START) || (state == ST_SEND) ||
                                 (state == ST_WAIT_DONE))
                                ? (16'(beat_cnt) + 16'(HDR_WORDS)) << 2 : 16'h0;

   assign bus.udp_tx_data = (data_sel == SEL_BUF) ? buf_rdata :
                            (data_sel == SEL_HDR) ? hdr_q : 32'h0;

   // State register.
   always_ff @(posedge gmii_rx_clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic and handshake outputs; B wins over R in IDLE.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_nxt                = state;
      bus.MASTER_RD_DATA_READY = 1'b0;
      bus.MASTER_WR_BACK_READY = 1'b0;
      bus.udp_tx_start         = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.MASTER_WR_BACK_READY = bus.MASTER_WR_BACK_VALID;
            if (bus.MASTER_WR_BACK_VALID)      state_nxt = ST_START;
            else if (bus.MASTER_RD_DATA_VALID) state_nxt = ST_COLLECT;
         end
         ST_COLLECT: begin
            bus.MASTER_RD_DATA_READY = 1'b1;
            if (bus.MASTER_RD_DATA_VALID && bus.MASTER_RD_DATA_LAST) state_nxt = ST_START;
         end
         ST_START: begin
            bus.udp_tx_start = 1'b1;
            state_nxt        = ST_SEND;
         end
         ST_SEND: begin
            if (bus.udp_tx_done)                state_nxt = ST_IDLE;
            else if (word_issue && last_word)   state_nxt = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (bus.udp_tx_done) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Frame bookkeeping: capture id/resp/beats, then walk the word index.
   always_ff @(posedge gmii_rx_clk or negedge rstn) begin
      if (!rstn) begin
         beat_cnt <= '0;
         w_idx    <= '0;
         id_q     <= '0;
         resp_acc <= '0;
         ovf      <= 1'b0;
         is_wr    <= 1'b0;
         data_sel <= SEL_ZERO;
         hdr_q    <= '0;
      end else if (frame_end) begin
         beat_cnt <= '0;
         w_idx    <= '0;
         resp_acc <= '0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (b_hs) begin
                  id_q     <= bus.MASTER_WR_BACK_ID;
                  resp_acc <= bus.MASTER_WR_BACK_RESP;
                  is_wr    <= 1'b1;
                  beat_cnt <= '0;
               end else if (bus.MASTER_RD_DATA_VALID) begin
                  is_wr <= 1'b0;
               end
            end
            ST_COLLECT: begin
               if (r_hs) begin
                  if (!buf_full) beat_cnt <= beat_cnt + 1'b1;
                  else           ovf      <= 1'b1;
                  if (bus.MASTER_RD_DATA_RESP > resp_acc) resp_acc <= bus.MASTER_RD_DATA_RESP;
                  if (beat_cnt == '0) id_q <= bus.MASTER_RD_BACK_ID;
               end
            end
            ST_SEND: begin
               if (bus.udp_tx_req) begin
                  w_idx <= w_idx + 1'b1;
                  if (w_idx < (BUF_AW+2)'(HDR_WORDS)) begin
                     data_sel <= SEL_HDR;
                     hdr_q    <= (w_idx == '0) ? hdr0 : hdr1;
                  end else begin
                     data_sel <= SEL_BUF;
                  end
               end
            end
            ST_WAIT_DONE: begin
               if (bus.udp_tx_req) data_sel <= SEL_ZERO;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_axi_resp_tx.sv
// Self-checking bench for udp_axi_resp_tx: stimulus pushes expected frames
// into a scoreboard, an independent tx-engine monitor pops and compares.
module tb_udp_axi_resp_tx;

   logic gmii_rx_clk = 1'b0;
   logic rstn;
   always #4 gmii_rx_clk = ~gmii_rx_clk;

   udp_axi_resp_tx_if bus();

   udp_axi_resp_tx #(.MAX_BEATS(256), .BUF_AW(8)) dut (
      .gmii_rx_clk(gmii_rx_clk),
      .rstn       (rstn),
      .bus        (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboard
   int          exp_bn[$];
   logic [31:0] exp_word[$];
   int          frames_exp  = 0;
   int          frames_done = 0;

   // Monitor configuration for the next frame(s)
   int gap_cfg   = 0;
   int extra_cfg = 0;
   int abort_at  = -1;

   // Current burst under construction
   logic [31:0] beat_data[$];
   logic [1:0]  beat_resp[$];

   // Per-frame monitor flags
   bit          mon_bp_bad;
   bit          mon_bn_bad;
   logic [15:0] mon_bn;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void expect_rd(input logic [3:0] id);
      int n, stored, rmax, len;
      logic [31:0] h;
      n      = beat_data.size();
      stored = (n > 256) ? 256 : n;
      rmax   = 0;
      foreach (beat_resp[i]) if (int'(beat_resp[i]) > rmax) rmax = int'(beat_resp[i]);
      len = (stored - 1) % 256;
      h   = 32'h0100_0000 + ((n > 256) ? 32'h0080_0000 : 32'h0) +
            32'(id) * 32'h0001_0000 + 32'(len);
      exp_bn.push_back(4 * (2 + stored));
      exp_word.push_back(h);
      exp_word.push_back(32'(rmax));
      for (int i = 0; i < stored; i++) exp_word.push_back(beat_data[i]);
      frames_exp++;
   endfunction

   function automatic void expect_wr(input logic [3:0] id, input logic [1:0] resp);
      exp_bn.push_back(8);
      exp_word.push_back(32'h0200_0000 + 32'(id) * 32'h0001_0000);
      exp_word.push_back(32'(resp));
      frames_exp++;
   endfunction

   task automatic gen_burst(input int n);
      beat_data.delete();
      beat_resp.delete();
      for (int i = 0; i < n; i++) begin
         beat_data.push_back($urandom);
         beat_resp.push_back(2'($urandom_range(0, 3)));
      end
   endtask

   // ---------------- AXI drivers ----------------
   task automatic drive_r(input logic [3:0] id, input bit gaps);
      int n, hs, budget;
      bit ok;
      n  = beat_data.size();
      hs = 0;
      ok = 1;
      for (int i = 0; i < n && ok; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.MASTER_RD_DATA_VALID = 1'b0;
            @(negedge gmii_rx_clk);
         end
         bus.MASTER_RD_BACK_ID    = id;
         bus.MASTER_RD_DATA       = beat_data[i];
         bus.MASTER_RD_DATA_RESP  = beat_resp[i];
         bus.MASTER_RD_DATA_LAST  = (i == n - 1);
         bus.MASTER_RD_DATA_VALID = 1'b1;
         budget = 0;
         #1;
         while (bus.MASTER_RD_DATA_READY !== 1'b1 && budget < 3000) begin
            @(negedge gmii_rx_clk);
            #1;
            budget++;
         end
         if (budget >= 3000) ok = 0;
         else begin
            @(negedge gmii_rx_clk);
            hs++;
         end
      end
      bus.MASTER_RD_DATA_VALID = 1'b0;
      bus.MASTER_RD_DATA_LAST  = 1'b0;
      check("r_beats_accepted", 32'(hs), 32'(n));
   endtask

   task automatic drive_b(input logic [3:0] id, input logic [1:0] resp, input bit chk_now);
      int budget;
      bus.MASTER_WR_BACK_ID    = id;
      bus.MASTER_WR_BACK_RESP  = resp;
      bus.MASTER_WR_BACK_VALID = 1'b1;
      #1;
      if (chk_now) check("bready_same_cycle", 32'(bus.MASTER_WR_BACK_READY), 32'h1);
      budget = 0;
      while (bus.MASTER_WR_BACK_READY !== 1'b1 && budget < 3000) begin
         @(negedge gmii_rx_clk);
         #1;
         budget++;
      end
      check("b_accepted", 32'(budget < 3000), 32'h1);
      @(negedge gmii_rx_clk);
      bus.MASTER_WR_BACK_VALID = 1'b0;
   endtask

   task automatic wait_frames();
      int budget;
      budget = 0;
      while (frames_done < frames_exp && budget < 5000) begin
         @(negedge gmii_rx_clk);
         budget++;
      end
      check("frames_completed", 32'(frames_done), 32'(frames_exp));
      repeat (2) @(negedge gmii_rx_clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_start"},   32'(bus.udp_tx_start), 32'h0);
      check({tag, "_bytenum"}, 32'(bus.udp_tx_byte_num), 32'h0);
      check({tag, "_data"},    bus.udp_tx_data, 32'h0);
      check({tag, "_rready"},  32'(bus.MASTER_RD_DATA_READY), 32'h0);
      check({tag, "_bready"},  32'(bus.MASTER_WR_BACK_READY), 32'h0);
   endtask

   // ---------------- UDP tx engine monitor ----------------
   task automatic mon_tick();
      @(negedge gmii_rx_clk);
      if (bus.MASTER_RD_DATA_READY !== 1'b0 || bus.MASTER_WR_BACK_READY !== 1'b0) mon_bp_bad = 1;
      if (bus.udp_tx_byte_num !== mon_bn) mon_bn_bad = 1;
   endtask

   task automatic handle_frame();
      int nw;
      logic [31:0] last_w, w_exp;
      mon_bp_bad = 0;
      mon_bn_bad = 0;
      if (exp_bn.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_start: byte_num=%0d with empty scoreboard", bus.udp_tx_byte_num);
         mon_bn = bus.udp_tx_byte_num;
         nw     = 0;
      end else begin
         mon_bn = 16'(exp_bn.pop_front());
         check("byte_num", 32'(bus.udp_tx_byte_num), 32'(mon_bn));
         nw = int'(mon_bn) / 4;
      end
      mon_tick();
      check("start_one_cycle", 32'(bus.udp_tx_start), 32'h0);
      last_w = '0;
      for (int i = 0; i < nw; i++) begin
         if (i == abort_at) begin
            for (int k = i; k < nw; k++) if (exp_word.size() > 0) void'(exp_word.pop_front());
            abort_at = -1;
            frames_done++;
            return;
         end
         for (int g = 0; g < gap_cfg; g++) begin
            mon_tick();
            if (i > 0) check("data_hold", bus.udp_tx_data, last_w);
         end
         bus.udp_tx_req = 1'b1;
         mon_tick();
         bus.udp_tx_req = 1'b0;
         w_exp = (exp_word.size() > 0) ? exp_word.pop_front() : 32'hDEAD_BEEF;
         check($sformatf("word%0d", i), bus.udp_tx_data, w_exp);
         last_w = w_exp;
      end
      for (int e = 0; e < extra_cfg; e++) begin
         bus.udp_tx_req = 1'b1;
         mon_tick();
         bus.udp_tx_req = 1'b0;
         check("extra_req_zero", bus.udp_tx_data, 32'h0);
      end
      check("byte_num_stable", 32'(mon_bn_bad), 32'h0);
      check("no_axi_ready_in_frame", 32'(mon_bp_bad), 32'h0);
      bus.udp_tx_done = 1'b1;
      @(negedge gmii_rx_clk);
      bus.udp_tx_done = 1'b0;
      frames_done++;
   endtask

   initial begin : monitor
      bus.udp_tx_req  = 1'b0;
      bus.udp_tx_done = 1'b0;
      forever begin
         @(negedge gmii_rx_clk);
         if (bus.udp_tx_start === 1'b1) handle_frame();
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin : stimulus
      logic [3:0] id_a, id_b;
      logic [1:0] resp_b;

      bus.MASTER_RD_BACK_ID    = '0;
      bus.MASTER_RD_DATA       = '0;
      bus.MASTER_RD_DATA_RESP  = '0;
      bus.MASTER_RD_DATA_LAST  = 1'b0;
      bus.MASTER_RD_DATA_VALID = 1'b0;
      bus.MASTER_WR_BACK_ID    = '0;
      bus.MASTER_WR_BACK_RESP  = '0;
      bus.MASTER_WR_BACK_VALID = 1'b0;
      rstn = 1'b0;
      repeat (3) @(negedge gmii_rx_clk);
      #1;
      check_idle_outputs("reset");
      @(negedge gmii_rx_clk);
      rstn = 1'b1;
      repeat (2) @(negedge gmii_rx_clk);

      // 1: four-beat read, ID 3
      beat_data = '{32'h11, 32'h22, 32'h33, 32'h44};
      beat_resp = '{2'd0, 2'd0, 2'd0, 2'd0};
      expect_rd(4'd3);
      drive_r(4'd3, 1'b0);
      wait_frames();

      // 2: write response, ID 5, RESP 2
      expect_wr(4'd5, 2'd2);
      drive_b(4'd5, 2'd2, 1'b1);
      wait_frames();

      // 3: B and R valid together; write frame first, read intact afterwards
      id_a   = 4'($urandom_range(0, 15));
      id_b   = 4'($urandom_range(0, 15));
      resp_b = 2'($urandom_range(0, 3));
      gen_burst(6);
      expect_wr(id_b, resp_b);
      expect_rd(id_a);
      fork
         drive_b(id_b, resp_b, 1'b1);
         drive_r(id_a, 1'b0);
      join
      wait_frames();

      // 4: 300-beat burst overflows the 256-word buffer
      gen_burst(300);
      id_a = 4'($urandom_range(0, 15));
      expect_rd(id_a);
      drive_r(id_a, 1'b1);
      wait_frames();

      // 5: gapped requests and two extra requests past the end
      gap_cfg   = 3;
      extra_cfg = 2;
      gen_burst(5);
      id_a = 4'($urandom_range(0, 15));
      expect_rd(id_a);
      drive_r(id_a, 1'b0);
      wait_frames();
      gap_cfg   = 0;
      extra_cfg = 0;

      // 6: reset in the middle of SEND, then a clean read
      abort_at = 3;
      gen_burst(8);
      id_a = 4'($urandom_range(0, 15));
      expect_rd(id_a);
      drive_r(id_a, 1'b0);
      wait_frames();
      #2;
      rstn = 1'b0;
      #1;
      check_idle_outputs("midsend_reset");
      repeat (2) @(negedge gmii_rx_clk);
      rstn = 1'b1;
      repeat (2) @(negedge gmii_rx_clk);
      gen_burst(7);
      id_a = 4'($urandom_range(0, 15));
      expect_rd(id_a);
      drive_r(id_a, 1'b1);
      wait_frames();

      // Randomized mix of reads and write responses
      for (int t = 0; t < 10; t++) begin
         id_a = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) begin
            resp_b = 2'($urandom_range(0, 3));
            expect_wr(id_a, resp_b);
            drive_b(id_a, resp_b, 1'b1);
         end else begin
            gen_burst(int'($urandom_range(1, 24)));
            expect_rd(id_a);
            drive_r(id_a, 1'b1);
         end
         wait_frames();
      end

      check("scoreboard_words_drained", 32'(exp_word.size()), 32'h0);
      check("scoreboard_frames_drained", 32'(exp_bn.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
